// File: rtl/delay_line_pipe.sv
// Shift-register delay line with stall, flush and occupancy count; data and valid move together.
// Optional macro DELAY_LINE_TAPS_EN adds the taps port exposing every stage register.
module delay_line_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       d,
    input  logic                   d_valid,
    output logic [WIDTH-1:0]       q,
    output logic                   q_valid,
    output logic [OCC_W-1:0]       occupancy
`ifdef DELAY_LINE_TAPS_EN
    ,
    output logic [DEPTH*WIDTH-1:0] taps
`endif
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_nxt;
    logic [OCC_W-1:0] occ_q;

    function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] v);
        logic [OCC_W-1:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            c = c + OCC_W'(v[i]);
        end
        return c;
    endfunction

    // Next-state valid vector; occupancy is the popcount of this so it lands on the same edge as vld_q.
    always_comb begin
        vld_nxt = vld_q;
        if (flush) begin
            vld_nxt = '0;
        end else if (en) begin
            vld_nxt[0] = d_valid;
            for (int i = 1; i < DEPTH; i++) begin
                vld_nxt[i] = vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            occ_q <= '0;
        end else begin
            vld_q <= vld_nxt;
            occ_q <= popcount(vld_nxt);
        end
    end

    // Data stages reset and flush to RESET_VAL so q never carries X after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RESET_VAL;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RESET_VAL;
            end
        end else if (en) begin
            stage_q[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q         = stage_q[DEPTH-1];
    assign q_valid   = vld_q[DEPTH-1];
    assign occupancy = occ_q;

`ifdef DELAY_LINE_TAPS_EN
    for (genvar g = 0; g < DEPTH; g++) begin : g_taps
        assign taps[g*WIDTH +: WIDTH] = stage_q[g];
    end
`endif

endmodule
